moving_average_mc: RTL and testbench
====================================

// Module: moving_average_mc
// PURPOSE
//  Multi-channel, TDM moving-average filter with run-time window length N = 2**log2n.
//  Computes y[n] = y[n-1] + x[n] - x[n-N] per channel on signed samples.
//  One shared read-first BRAM holds all channel delay lines.
//  Sits after the ADC channel mux; output feeds the per-channel decimator/threshold logic.
// PARAMETERS
//  G_I_W        12  signed input/output sample width
//  G_M_W_MAX    6   log2 of maximum window; BRAM depth per channel = 2**G_M_W_MAX
//  G_CH         4   number of channels (>=1)
//  G_CH_W       $clog2(G_CH) (min 1)  channel index width, derived
//  G_LOG2N_RST  4   window exponent loaded at reset
// PORTS
//  i_clk         in   1            clock
//  i_rst         in   1            reset; synchronous, active-high; clock i_clk
//  i_valid       in   1            sample strobe; accepted when i_valid && o_ready
//  i_ch          in   G_CH_W       channel of i_sample (values >= G_CH ignored, not accepted)
//  i_sample      in   G_I_W        signed sample
//  i_cfg_we      in   1            load new window exponent; honoured only when o_ready
//  i_cfg_log2n   in   $clog2(G_M_W_MAX+1)  new exponent; values > G_M_W_MAX clamp to G_M_W_MAX
//  o_ready       out  1            high in IDLE; low while clearing
//  o_valid       out  1            result strobe
//  o_ch          out  G_CH_W       channel of o_result
//  o_result      out  G_I_W        signed rounded mean
//  o_primed      out  1            channel has received >= N samples since last clear
//  o_log2n       out  $clog2(G_M_W_MAX+1)  active window exponent
// BEHAVIOUR
//  FSM: CLEAR -> IDLE. CLEAR walks BRAM addr 0..G_CH*2**G_M_W_MAX-1, writing 0, one per cycle.
//   Entered on i_rst and on accepted i_cfg_we. Returns to IDLE after the last address.
//  In CLEAR: o_ready=0; per-channel acc, ptr and fill count zeroed; inputs ignored.
//   o_valid=0 for all in-flight pipeline entries (dropped, not delayed).
//  Reset values: o_valid=0, o_ch=0, o_result=0, o_primed=0, o_ready=0, o_log2n=G_LOG2N_RST.
//  Pipeline, latency 3 cycles from accept to o_valid, throughput 1 sample/cycle, any channel order:
//   S0: addr={ch,ptr[ch]}; read-first: read old x[n-N], write x[n]; ptr[ch]<=(ptr+1) mod N.
//   S1: sub = sext(x[n]) - sext(x[n-N]), G_I_W+1 bits signed.
//   S2: acc[ch] <= acc[ch] + sext(sub); acc is G_I_W+G_M_W_MAX bits signed, never overflows.
//  Back-to-back samples on one channel: acc[ch] is read and written in S2 only, so no hazard.
//  Same-address read-first: a given ptr is revisited only after N accepts on that channel.
//  Output:
//   o_result = (acc_new + (log2n>0 ? 2**(log2n-1) : 0)) >>> log2n, truncated to G_I_W.
//   acc_new is the accumulator value after the S2 update.
//   Rounding is round-half-up; log2n=0 is passthrough (o_result = x[n]).
//  Fill count per channel saturates at N; o_primed = count_after_update >= N, reported with the result.
//  Before primed, missing samples count as 0, so the mean ramps up from 0.
//  i_cfg_we with i_valid same cycle: the sample is discarded, config wins, CLEAR starts next cycle.
//  i_rst mid-CLEAR restarts the walk from address 0 and reloads G_LOG2N_RST.
// STRUCTURE
//  moving_average_pkg: state_t enum {ST_CLEAR, ST_IDLE}; functions for acc/sub width;
//   clamp_log2n().
//  Sub-module ma_sample_ram: single-port read-first RAM, G_I_W x G_CH*2**G_M_W_MAX, 1-cycle read.
//  Per-channel ptr/acc/count arrays are kept as registers in moving_average_mc.
// TESTING
//  Reset, then wait the CLEAR length (G_CH*64 cycles): o_ready rises; o_log2n=4; no o_valid seen.
//  log2n=2, ch0 constant +100 every cycle:
//   o_result = 25, 50, 75, 100, 100 ...; o_primed first 1 on the 4th result; latency 3.
//  log2n=3, ch1 alternating -8,+8: after priming o_result=0.
//   A single +1 step on the ch1 stream checks round-half-up of negatives (-1/8 -> 0).
//  Interleave ch0..ch3 round-robin with values ch*10, log2n=0:
//   o_result equals the input, o_ch matches, channels stay isolated.
//  Mid-stream i_cfg_we, log2n=6, with i_valid high:
//   sample dropped; in-flight outputs suppressed; o_ready low for the CLEAR length.
//   Next results restart from a ramp of 1/64 steps.
//  Full-scale -2048 on ch2, log2n=6: accumulator reaches -131072 without overflow; o_result=-2048.

Source files
------------

// File: rtl/moving_average_pkg.sv
// moving_average_pkg: shared state encoding and width helpers for the TDM moving-average filter
package moving_average_pkg;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  function automatic int acc_w(input int i_w, input int m_w);
    return i_w + m_w;
  endfunction
  function automatic int sub_w(input int i_w);
    return i_w + 1;
  endfunction
  function automatic int clamp_log2n(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction
endpackage

// File: rtl/ma_sample_ram.sv
// ma_sample_ram: single-port read-first RAM holding every channel's delay line
module ma_sample_ram #(
  parameter int W = 12,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/moving_average_mc.sv
// moving_average_mc: multi-channel TDM moving-average filter with run-time window 2**log2n
module moving_average_mc
  import moving_average_pkg::*;
#(
  parameter int G_I_W = 12,
  parameter int G_M_W_MAX = 6,
  parameter int G_CH = 4,
  parameter int G_LOG2N_RST = 4,
  localparam int G_CH_W = (G_CH > 1) ? $clog2(G_CH) : 1,
  localparam int L_W = $clog2(G_M_W_MAX + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [G_CH_W-1:0]       i_ch,
  input  logic signed [G_I_W-1:0] i_sample,
  input  logic                    i_cfg_we,
  input  logic [L_W-1:0]          i_cfg_log2n,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [G_CH_W-1:0]       o_ch,
  output logic signed [G_I_W-1:0] o_result,
  output logic                    o_primed,
  output logic [L_W-1:0]          o_log2n
);
  localparam int A_W = acc_w(G_I_W, G_M_W_MAX);
  localparam int S_W = sub_w(G_I_W);
  localparam int DEPTH = G_CH << G_M_W_MAX;
  localparam int AD_W = G_CH_W + G_M_W_MAX;
  state_t state;
  logic [AD_W-1:0] clr_addr, ram_addr;
  logic [G_M_W_MAX-1:0] ptr [G_CH];
  logic signed [A_W-1:0] acc [G_CH];
  logic [G_M_W_MAX:0] cnt [G_CH];
  logic [L_W-1:0] log2n;
  logic cfg_acc, acc_en, kill, ram_we;
  logic s1_v, s2_v;
  logic [G_CH_W-1:0] s1_ch, s2_ch;
  logic signed [G_I_W-1:0] s1_x, x_old, ram_wdata;
  logic signed [S_W-1:0] s2_sub;
  logic signed [A_W-1:0] acc_new;
  logic signed [A_W:0] rnd, rnd_sum;
  logic [G_M_W_MAX:0] n_val, cnt_new;
  logic [G_M_W_MAX-1:0] ptr_mask;
  assign o_ready = state == ST_IDLE;
  assign o_log2n = log2n;
  assign cfg_acc = i_cfg_we && o_ready;
  assign acc_en = i_valid && o_ready && !i_cfg_we && (int'(i_ch) < G_CH);
  // anything still in the pipeline when a clear begins is dropped, not delayed
  assign kill = !o_ready || i_cfg_we;
  assign n_val = (G_M_W_MAX + 1)'(1) << log2n;
  assign ptr_mask = G_M_W_MAX'(n_val - 1'b1);
  assign ram_addr = o_ready ? {i_ch, ptr[i_ch]} : clr_addr;
  assign ram_we = !o_ready || acc_en;
  assign ram_wdata = o_ready ? i_sample : '0;
  assign acc_new = acc[s2_ch] + A_W'(s2_sub);
  assign cnt_new = (cnt[s2_ch] >= n_val) ? n_val : cnt[s2_ch] + 1'b1;
  assign rnd = (log2n == '0) ? '0 : (A_W + 1)'(1) << (log2n - 1'b1);
  assign rnd_sum = acc_new + rnd;
  ma_sample_ram #(.W(G_I_W), .DEPTH(DEPTH), .AW(AD_W)) u_ram (
    .i_clk(i_clk),
    .we(ram_we),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(x_old)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_CLEAR;
      clr_addr <= '0;
      log2n <= L_W'(G_LOG2N_RST);
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      o_valid <= 1'b0;
      o_ch <= '0;
      o_result <= '0;
      o_primed <= 1'b0;
    end else begin
      s1_v <= acc_en;
      s2_v <= s1_v && !kill;
      o_valid <= s2_v && !kill;
      if (s2_v && !kill) begin
        o_ch <= s2_ch;
        o_result <= G_I_W'(rnd_sum >>> log2n);
        o_primed <= cnt_new >= n_val;
      end
      if (cfg_acc) begin
        state <= ST_CLEAR;
        clr_addr <= '0;
        log2n <= L_W'(clamp_log2n(int'(i_cfg_log2n), G_M_W_MAX));
      end else if (!o_ready) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == AD_W'(DEPTH - 1)) state <= ST_IDLE;
      end
    end
  end
  // per-channel state is read and written only in S2, so back-to-back samples never race
  always_ff @(posedge i_clk) begin
    s1_ch <= i_ch;
    s1_x <= i_sample;
    s2_ch <= s1_ch;
    s2_sub <= S_W'(s1_x) - S_W'(x_old);
    if (s2_v && !kill) begin
      acc[s2_ch] <= acc_new;
      cnt[s2_ch] <= cnt_new;
    end
    if (acc_en) ptr[i_ch] <= (ptr[i_ch] + 1'b1) & ptr_mask;
    if (!o_ready)
      for (int c = 0; c < G_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
        ptr[c] <= '0;
      end
  end
endmodule

// File: tb/tb_moving_average_mc.sv
// tb_moving_average_mc: scoreboard bench with a window-sum reference model per channel
module tb_moving_average_mc;
  typedef struct {
    int ch;
    logic signed [11:0] res;
    logic primed;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_valid = 1'b0;
  logic [1:0] i_ch = '0;
  logic signed [11:0] i_sample = '0;
  logic i_cfg_we = 1'b0;
  logic [2:0] i_cfg_log2n = '0;
  logic o_ready, o_valid, o_primed;
  logic [1:0] o_ch;
  logic signed [11:0] o_result;
  logic [2:0] o_log2n;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  int hist[4][64];
  int mcnt[4];
  int l2n = 4;

  moving_average_mc dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_ch(i_ch), .i_sample(i_sample),
    .i_cfg_we(i_cfg_we), .i_cfg_log2n(i_cfg_log2n), .o_ready(o_ready), .o_valid(o_valid),
    .o_ch(o_ch), .o_result(o_result), .o_primed(o_primed), .o_log2n(o_log2n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: ch=%0d result=%0d at cycle %0d, required no output", o_ch, o_result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (o_ch !== 2'(e.ch) || o_result !== e.res || o_primed !== e.primed || cyc != e.due) begin
          errors++;
          $display("FAIL output: got ch=%0d result=%0d primed=%0b cycle=%0d, required ch=%0d result=%0d primed=%0b cycle=%0d",
                   o_ch, o_result, o_primed, cyc, e.ch, e.res, e.primed, e.due);
        end
      end
    end
  end

  task automatic model_clear();
    for (int c = 0; c < 4; c++) mcnt[c] = 0;
  endtask

  task automatic send(input int ch, input int x);
    exp_t e;
    int s, n;
    n = 1 << l2n;
    hist[ch][mcnt[ch] % 64] = x;
    mcnt[ch]++;
    s = 0;
    for (int j = 0; j < n; j++)
      if (mcnt[ch] - 1 - j >= 0) s += hist[ch][(mcnt[ch] - 1 - j) % 64];
    e.ch = ch;
    e.res = 12'((s + (l2n > 0 ? (1 << (l2n - 1)) : 0)) >>> l2n);
    e.primed = mcnt[ch] >= n;
    e.due = cyc + 3;
    q.push_back(e);
    i_valid = 1'b1;
    i_ch = 2'(ch);
    i_sample = 12'(x);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // counts cycles with o_ready low starting from the current cycle
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL %s_clear_len: got %0d cycles of o_ready low, required 256", name, n);
    end
  endtask

  task automatic drain(input string name);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending, required 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic set_log2n(input int v, input string name);
    while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
    i_cfg_we = 1'b1;
    i_cfg_log2n = 3'(v);
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
    l2n = (v > 6) ? 6 : v;
    model_clear();
    i_valid = 1'b1;
    i_ch = 2'd0;
    i_sample = 12'sd77;
    wait_ready(name);
    i_valid = 1'b0;
    checks++;
    if (o_log2n !== 3'(l2n)) begin
      errors++;
      $display("FAIL %s_log2n: got %0d, required %0d", name, o_log2n, l2n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ch !== 2'd0 || o_result !== 12'sd0 || o_primed !== 1'b0 || o_ready !== 1'b0 || o_log2n !== 3'd4) begin
      errors++;
      $display("FAIL reset_values: got valid=%0b ch=%0d result=%0d primed=%0b ready=%0b log2n=%0d, required 0 0 0 0 0 4",
               o_valid, o_ch, o_result, o_primed, o_ready, o_log2n);
    end
    i_rst = 1'b0;
    model_clear();
    l2n = 4;
    wait_ready("reset");
    checks++;
    if (o_log2n !== 3'd4) begin
      errors++;
      $display("FAIL reset_log2n: got %0d, required 4", o_log2n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mean();
    set_log2n(2, "mean");
    for (int i = 0; i < 8; i++) send(0, 100);
    drain("mean");
  endtask

  task automatic test_round();
    set_log2n(3, "round");
    for (int i = 0; i < 16; i++) send(1, (i % 2) ? 8 : -8);
    send(1, -7);
    send(1, 8);
    send(1, -8);
    send(1, 7);
    for (int i = 0; i < 8; i++) send(1, (i % 2) ? 8 : -8);
    drain("round");
  endtask

  task automatic test_interleave();
    set_log2n(0, "interleave");
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) send(c, c * 10 - r);
    drain("interleave");
  endtask

  task automatic test_cfg_midstream();
    for (int i = 0; i < 5; i++) send(3, 50 + i);
    i_valid = 1'b1;
    i_ch = 2'd3;
    i_sample = 12'sd999;
    set_log2n(6, "midstream");
    for (int i = 0; i < 4; i++) send(0, 640);
    drain("midstream");
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < 70; i++) send(2, -2048);
    drain("full_scale");
  endtask

  task automatic test_clamp();
    set_log2n(7, "clamp");
    for (int i = 0; i < 3; i++) send(1, 64);
    drain("clamp");
  endtask

  initial begin
    test_reset();
    test_mean();
    test_round();
    test_interleave();
    test_cfg_midstream();
    test_full_scale();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
